// File: rtl/mdu_unit_pkg.sv
// Shared encodings for the multiply/divide unit: op codes, FSM states and
// the operand-magnitude helper used by the divider.
package mdu_unit_pkg;

    localparam int DATA_WIDTH = 32;

    typedef enum logic [2:0] {
        MDU_OP_NOP   = 3'd0,
        MDU_OP_MULT  = 3'd1,
        MDU_OP_MULTU = 3'd2,
        MDU_OP_DIV   = 3'd3,
        MDU_OP_DIVU  = 3'd4,
        MDU_OP_MTHI  = 3'd5,
        MDU_OP_MTLO  = 3'd6,
        MDU_OP_RSVD  = 3'd7
    } mdu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DIV  = 2'd1,
        ST_DONE = 2'd2
    } mdu_state_e;

    function automatic logic [DATA_WIDTH-1:0] mdu_mag(input logic [DATA_WIDTH-1:0] v,
                                                      input logic neg);
        return neg ? (~v + 1'b1) : v;
    endfunction

endpackage

// File: rtl/mdu_unit_if.sv
// EX-side request bus and HI/LO write-back bus of the multiply/divide unit.
interface mdu_unit_if;
    import mdu_unit_pkg::*;

    logic                  start;
    logic [2:0]            op;
    logic [DATA_WIDTH-1:0] op_a;
    logic [DATA_WIDTH-1:0] op_b;
    logic                  flush;
    logic [DATA_WIDTH-1:0] hi_cur;
    logic [DATA_WIDTH-1:0] lo_cur;
    logic                  busy;
    logic                  write_en;
    logic [DATA_WIDTH-1:0] hi_out;
    logic [DATA_WIDTH-1:0] lo_out;

    modport master (
        output start, op, op_a, op_b, flush, hi_cur, lo_cur,
        input  busy, write_en, hi_out, lo_out
    );

    modport slave (
        input  start, op, op_a, op_b, flush, hi_cur, lo_cur,
        output busy, write_en, hi_out, lo_out
    );

endinterface

// File: rtl/mdu_unit_div_core.sv
// Radix-2 restoring divider: one quotient bit per cycle on operand magnitudes,
// sign fix-up folded into the final iteration.
module mdu_unit_div_core
    import mdu_unit_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  flush,
    input  logic                  is_signed,
    input  logic [DATA_WIDTH-1:0] dividend,
    input  logic [DATA_WIDTH-1:0] divisor,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] quotient,
    output logic [DATA_WIDTH-1:0] remainder
);
    localparam int CNT_W = $clog2(DATA_WIDTH);

    logic                  running;
    logic [CNT_W-1:0]      cnt;
    logic [DATA_WIDTH-1:0] dvs;
    logic [DATA_WIDTH-1:0] quo;
    logic [DATA_WIDTH-1:0] rem;
    logic                  neg_q;
    logic                  neg_r;
    logic                  sign_a;
    logic                  sign_b;
    logic [DATA_WIDTH:0]   trial;
    logic [DATA_WIDTH-1:0] rem_n;
    logic [DATA_WIDTH-1:0] quo_n;

    assign sign_a    = is_signed & dividend[DATA_WIDTH-1];
    assign sign_b    = is_signed & divisor[DATA_WIDTH-1];
    assign done      = running && (cnt == '0);
    assign quotient  = quo;
    assign remainder = rem;

    // Borrow out of the 33-bit trial subtract means the divisor did not fit.
    always_comb begin
        trial = {rem, quo[DATA_WIDTH-1]} - {1'b0, dvs};
        if (trial[DATA_WIDTH]) begin
            rem_n = {rem[DATA_WIDTH-2:0], quo[DATA_WIDTH-1]};
            quo_n = {quo[DATA_WIDTH-2:0], 1'b0};
        end else begin
            rem_n = trial[DATA_WIDTH-1:0];
            quo_n = {quo[DATA_WIDTH-2:0], 1'b1};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            running <= 1'b0;
            cnt     <= '0;
            dvs     <= '0;
            quo     <= '0;
            rem     <= '0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
        end else if (flush) begin
            running <= 1'b0;
            cnt     <= '0;
        end else if (start) begin
            running <= 1'b1;
            cnt     <= CNT_W'(DATA_WIDTH - 1);
            dvs     <= mdu_mag(divisor, sign_b);
            quo     <= mdu_mag(dividend, sign_a);
            rem     <= '0;
            neg_q   <= sign_a ^ sign_b;
            neg_r   <= sign_a;
        end else if (running) begin
            cnt <= cnt - 1'b1;
            if (cnt == '0) begin
                running <= 1'b0;
                quo     <= mdu_mag(quo_n, neg_q);
                rem     <= mdu_mag(rem_n, neg_r);
            end else begin
                quo <= quo_n;
                rem <= rem_n;
            end
        end
    end

endmodule

// File: rtl/mdu_unit.sv
// Multiply/divide unit in EX: produces the HI/LO write-back for MULT/MULTU,
// DIV/DIVU (iterative, stalls via busy) and MTHI/MTLO.
//
// state   | meaning
// ST_IDLE | accepting ops; multiply, move and divide-by-zero retire next cycle
// ST_DIV  | divider iterating, one quotient bit per cycle
// ST_DONE | divide result ready; written to HI/LO on exit unless flushed
module mdu_unit
    import mdu_unit_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    mdu_unit_if.slave bus
);
    mdu_state_e              state;
    mdu_op_e                 op;
    logic                    accept;
    logic                    is_mul;
    logic                    is_div;
    logic                    div_by_zero;
    logic                    div_go;
    logic                    core_done;
    logic [DATA_WIDTH-1:0]   core_quo;
    logic [DATA_WIDTH-1:0]   core_rem;
    logic [2*DATA_WIDTH-1:0] prod_s;
    logic [2*DATA_WIDTH-1:0] prod_u;
    logic [2*DATA_WIDTH-1:0] product;

    assign op          = mdu_op_e'(bus.op);
    assign accept      = bus.start && !bus.flush && (state == ST_IDLE);
    assign is_mul      = (op == MDU_OP_MULT) || (op == MDU_OP_MULTU);
    assign is_div      = (op == MDU_OP_DIV) || (op == MDU_OP_DIVU);
    assign div_by_zero = (bus.op_b == '0);
    assign div_go      = accept && is_div && !div_by_zero;

    // Low 64 bits of a product of sign-extended operands equal the signed product.
    assign prod_s  = {{DATA_WIDTH{bus.op_a[DATA_WIDTH-1]}}, bus.op_a}
                   * {{DATA_WIDTH{bus.op_b[DATA_WIDTH-1]}}, bus.op_b};
    assign prod_u  = {{DATA_WIDTH{1'b0}}, bus.op_a} * {{DATA_WIDTH{1'b0}}, bus.op_b};
    assign product = (op == MDU_OP_MULT) ? prod_s : prod_u;

    mdu_unit_div_core u_div_core (
        .clk       (clk),
        .rst       (rst),
        .start     (div_go),
        .flush     (bus.flush),
        .is_signed (op == MDU_OP_DIV),
        .dividend  (bus.op_a),
        .divisor   (bus.op_b),
        .done      (core_done),
        .quotient  (core_quo),
        .remainder (core_rem)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= ST_IDLE;
            bus.busy     <= 1'b0;
            bus.write_en <= 1'b0;
            bus.hi_out   <= '0;
            bus.lo_out   <= '0;
        end else begin
            bus.write_en <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (accept) begin
                        if (is_mul) begin
                            bus.write_en <= 1'b1;
                            bus.hi_out   <= product[2*DATA_WIDTH-1:DATA_WIDTH];
                            bus.lo_out   <= product[DATA_WIDTH-1:0];
                        end else if (op == MDU_OP_MTHI) begin
                            bus.write_en <= 1'b1;
                            bus.hi_out   <= bus.op_a;
                            bus.lo_out   <= bus.lo_cur;
                        end else if (op == MDU_OP_MTLO) begin
                            bus.write_en <= 1'b1;
                            bus.hi_out   <= bus.hi_cur;
                            bus.lo_out   <= bus.op_a;
                        end else if (is_div && div_by_zero) begin
                            bus.write_en <= 1'b1;
                            bus.hi_out   <= bus.op_a;
                            bus.lo_out   <= '1;
                        end else if (is_div) begin
                            state    <= ST_DIV;
                            bus.busy <= 1'b1;
                        end
                    end
                end
                ST_DIV: begin
                    if (bus.flush) begin
                        state    <= ST_IDLE;
                        bus.busy <= 1'b0;
                    end else if (core_done) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state    <= ST_IDLE;
                    bus.busy <= 1'b0;
                    if (!bus.flush) begin
                        bus.write_en <= 1'b1;
                        bus.hi_out   <= core_rem;
                        bus.lo_out   <= core_quo;
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    bus.busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/mdu_unit.md
Name: mdu_unit

Overview:
- Multiply/divide unit that produces the write side of the HI/LO register pair: computes MULT/MULTU/DIV/DIVU results and handles MTHI/MTLO.
- Drives write_en/hi_out/lo_out into the HI/LO register block; reads the current HI/LO back for partial writes.
- Sits in EX. Multiplies and moves finish in one cycle; divides are iterative (radix-2 restoring), and the pipeline stalls on busy.

Parameters:
- DATA_WIDTH, 32, operand/result width; `DATA_BUS from define/bus.v covers [31:0].

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- start  in  1  accept op this cycle; ignored while busy
- op  in  3  operation code, sampled with start
- op_a  in  32  rs operand (dividend / multiplicand / MTHI-MTLO source)
- op_b  in  32  rt operand (divisor / multiplier)
- flush  in  1  cancel an in-flight divide (exception/eret)
- hi_cur  in  32  current HI from the HI/LO register block
- lo_cur  in  32  current LO from the HI/LO register block
- busy  out  1  divide in progress; pipeline holds EX
- write_en  out  1  one-cycle pulse; HI/LO block latches hi_out/lo_out
- hi_out  out  32  new HI value
- lo_out  out  32  new LO value

Behaviour:
- Reset (async, rst=0): state=IDLE, busy=0, write_en=0, hi_out=0, lo_out=0, counter=0, internal remainder/quotient=0.
- Op codes: 0 NOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 reserved (treated as NOP).
- States: IDLE, DIV, DONE.
- IDLE + start + op∈{1,2}:
  - 64-bit product registered, signed for op 1, unsigned for op 2.
  - Next cycle: write_en=1, hi_out=product[63:32], lo_out=product[31:0].
  - State stays IDLE.
- IDLE + start + op=5: next cycle write_en=1, hi_out=op_a, lo_out=lo_cur.
- IDLE + start + op=6: next cycle write_en=1, hi_out=hi_cur, lo_out=op_a.
- IDLE + start + op∈{3,4}, op_b≠0:
  - Latch the operand magnitudes (DIV takes abs values) and the sign flags.
  - counter=31; next state DIV.
- DIV:
  - One quotient bit per cycle, 32 cycles; counter decrements.
  - When counter=0, next state DONE.
- DONE: write_en=1, hi_out=remainder, lo_out=quotient; next state IDLE.
  - Signed fix-up is applied when entering DONE: quotient negated if the operand signs differ; remainder takes the dividend's sign.
- Divide latency: start at edge 0, write_en high in the cycle after edge 33. busy is high from edge 1 through the DONE cycle inclusive.
- Divide by zero (op 3/4, op_b=0):
  - No iteration; next cycle write_en=1, hi_out=op_a, lo_out=0xFFFFFFFF.
  - busy stays 0.
- Overflow case DIV 0x80000000 / 0xFFFFFFFF: lo_out=0x80000000, hi_out=0. No trap.
- start while busy: ignored, no state change.
- start in the DONE cycle: ignored. The pipeline must observe busy=1 there.
- flush:
  - In DIV or DONE: next state IDLE, write_en=0 (DONE result suppressed), busy=0 next cycle.
  - In IDLE: a coincident start is dropped and no write_en is produced.
- write_en is never high for more than one cycle per accepted op.
- hi_out/lo_out hold their last values when write_en=0.
- Reset mid-divide: immediate return to IDLE, all outputs to their reset values.

Decomposition:
- Op-code constants (MDU_OP_*) go in a shared header define/mdu.v, next to define/bus.v, so the decoder and EX use the same encoding.
- Sub-module div_core: restoring divider datapath with start/flush in, done/quotient/remainder out, 32-cycle iteration and signed fix-up.
- mdu_unit keeps the FSM, multiplier, MTHI/MTLO muxing and the output registers.

Test Plan:
- MULTU 0xFFFFFFFF×0xFFFFFFFF -> one cycle later write_en=1, hi_out=0xFFFFFFFE, lo_out=0x00000001. MULT on the same operands -> hi_out=0, lo_out=1.
- DIV op_a=0xFFFFFFF9 (-7), op_b=2:
  - busy high for 33 cycles.
  - write_en at cycle 33, lo_out=0xFFFFFFFD, hi_out=0xFFFFFFFF.
  - DIVU 100/7 -> lo_out=14, hi_out=2.
- MTHI op_a=0x12345678 with lo_cur=0xAAAA5555 -> write_en=1, hi_out=0x12345678, lo_out=0xAAAA5555. MTLO mirrors this.
- DIVU with op_b=0, op_a=0x55 -> busy never asserted; next cycle hi_out=0x55, lo_out=0xFFFFFFFF.
- DIV started, flush at cycle 10 -> no write_en pulse, busy=0 from cycle 11. A new MULTU 3×4 started at cycle 12 -> lo_out=12 at cycle 13.
- DIV started, rst pulsed low at cycle 5 asynchronously -> busy, write_en, hi_out and lo_out read 0 immediately. A start issued while busy -> ignored, no extra write_en.
